// File: rtl/pong_ball_ctrl.sv
// pong_ball_ctrl: frame-rate Pong game controller.
//   Collects per-pixel ball/paddle/wall overlaps into sticky hit flags over a
//   frame, then on each frame_tick bounces, moves, scores and sequences
//   IDLE -> SERVE_WAIT -> PLAY -> (SERVE_WAIT | OVER) -> IDLE.
// Ports:
//   clk, rst (async, active-high), frame_tick (1-clk pulse at vblank start)
//   ball_pix, paddle_1_pix, paddle_2_pix, top_pix, bot_pix : pixel overlaps
//   serve     : level button; a rising edge starts/restarts play
//   ball_x/ball_y : ball top-left, registered, change only on frame_tick
//   score_1/score_2 : left/right scores; in_play / game_over : state flags
module pong_ball_ctrl #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int BALL_SIZE    = 8,
  parameter int SPEED        = 2,
  parameter int SERVE_FRAMES = 60,
  parameter int WIN_SCORE    = 7,
  parameter int X_W          = 10,
  parameter int Y_W          = 10
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           frame_tick,
  input  logic           ball_pix,
  input  logic           paddle_1_pix,
  input  logic           paddle_2_pix,
  input  logic           top_pix,
  input  logic           bot_pix,
  input  logic           serve,
  output logic [X_W-1:0] ball_x,
  output logic [Y_W-1:0] ball_y,
  output logic [3:0]     score_1,
  output logic [3:0]     score_2,
  output logic           in_play,
  output logic           game_over
);

  typedef enum logic [1:0] {S_IDLE, S_SERVE_WAIT, S_PLAY, S_OVER} state_t;

  localparam int CNT_W = $clog2(SERVE_FRAMES + 1);
  localparam logic [X_W-1:0]   X_CTR    = X_W'((H_RES - BALL_SIZE) / 2);
  localparam logic [Y_W-1:0]   Y_CTR    = Y_W'((V_RES - BALL_SIZE) / 2);
  localparam logic [X_W-1:0]   X_SPD    = X_W'(SPEED);
  localparam logic [Y_W-1:0]   Y_SPD    = Y_W'(SPEED);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [3:0]       WIN      = 4'(WIN_SCORE);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [X_W-1:0]   r_x, w_x_nx;
  logic [Y_W-1:0]   r_y, w_y_nx;
  logic             r_dx_neg, w_dx_neg_nx;   // direction sign: 1 = moving left
  logic             r_dy_neg, w_dy_neg_nx;   // direction sign: 1 = moving up
  logic [3:0]       r_s1, w_s1_nx;
  logic [3:0]       r_s2, w_s2_nx;
  logic             r_hit_p1, r_hit_p2, r_hit_top, r_hit_bot;
  logic             r_serve_q;
  logic             r_in_play, r_game_over;

  logic           w_serve_rise;
  logic [X_W:0]   w_x_far;
  logic [X_W-1:0] w_dx;
  logic [Y_W-1:0] w_dy;

  assign w_serve_rise = serve & ~r_serve_q;
  // Right edge the ball would reach after one more step, one bit wider so it cannot wrap.
  assign w_x_far = {1'b0, r_x} + (X_W+1)'(BALL_SIZE + SPEED);

  always_comb begin
    w_state_nx  = r_state;
    w_cnt_nx    = r_cnt;
    w_x_nx      = r_x;
    w_y_nx      = r_y;
    w_dx_neg_nx = r_dx_neg;
    w_dy_neg_nx = r_dy_neg;
    w_s1_nx     = r_s1;
    w_s2_nx     = r_s2;
    w_dx        = X_SPD;
    w_dy        = Y_SPD;
    case (r_state)
      S_IDLE: begin
        w_x_nx = X_CTR;
        w_y_nx = Y_CTR;
        if (w_serve_rise) begin
          w_state_nx = S_SERVE_WAIT;
          w_cnt_nx   = '0;
        end
      end
      S_SERVE_WAIT: begin
        w_x_nx = X_CTR;
        w_y_nx = Y_CTR;
        if (frame_tick) begin
          if (r_cnt == CNT_LAST) w_state_nx = S_PLAY;
          else                   w_cnt_nx   = r_cnt + 1'b1;
        end
      end
      S_PLAY: begin
        if (frame_tick) begin
          // Bounce only toward the paddle/wall that was hit, so a ball still
          // overlapping after reversing is not flipped back.
          if (r_hit_p1 && r_dx_neg)       w_dx_neg_nx = 1'b0;
          else if (r_hit_p2 && !r_dx_neg) w_dx_neg_nx = 1'b1;
          if (r_hit_top && r_dy_neg)       w_dy_neg_nx = 1'b0;
          else if (r_hit_bot && !r_dy_neg) w_dy_neg_nx = 1'b1;

          if (w_dx_neg_nx && (r_x < X_SPD)) begin
            // Left goal: serve next toward the left player.
            w_s2_nx     = r_s2 + 1'b1;
            w_dx_neg_nx = 1'b1;
            w_x_nx      = X_CTR;
            w_y_nx      = Y_CTR;
            w_cnt_nx    = '0;
            w_state_nx  = (w_s2_nx == WIN) ? S_OVER : S_SERVE_WAIT;
          end else if (!w_dx_neg_nx && (w_x_far > (X_W+1)'(H_RES - 1))) begin
            w_s1_nx     = r_s1 + 1'b1;
            w_dx_neg_nx = 1'b0;
            w_x_nx      = X_CTR;
            w_y_nx      = Y_CTR;
            w_cnt_nx    = '0;
            w_state_nx  = (w_s1_nx == WIN) ? S_OVER : S_SERVE_WAIT;
          end else begin
            w_dx   = w_dx_neg_nx ? (X_W'(0) - X_SPD) : X_SPD;
            w_dy   = w_dy_neg_nx ? (Y_W'(0) - Y_SPD) : Y_SPD;
            w_x_nx = r_x + w_dx;
            w_y_nx = r_y + w_dy;
          end
        end
      end
      S_OVER: begin
        w_x_nx = X_CTR;
        w_y_nx = Y_CTR;
        if (w_serve_rise) begin
          w_s1_nx     = '0;
          w_s2_nx     = '0;
          w_dx_neg_nx = 1'b0;
          w_dy_neg_nx = 1'b0;
          w_state_nx  = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_x         <= X_CTR;
      r_y         <= Y_CTR;
      r_dx_neg    <= 1'b0;
      r_dy_neg    <= 1'b0;
      r_s1        <= '0;
      r_s2        <= '0;
      r_hit_p1    <= 1'b0;
      r_hit_p2    <= 1'b0;
      r_hit_top   <= 1'b0;
      r_hit_bot   <= 1'b0;
      r_serve_q   <= 1'b0;
      r_in_play   <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_cnt       <= w_cnt_nx;
      r_x         <= w_x_nx;
      r_y         <= w_y_nx;
      r_dx_neg    <= w_dx_neg_nx;
      r_dy_neg    <= w_dy_neg_nx;
      r_s1        <= w_s1_nx;
      r_s2        <= w_s2_nx;
      r_serve_q   <= serve;
      r_in_play   <= (w_state_nx == S_PLAY);
      r_game_over <= (w_state_nx == S_OVER);
      // A set coinciding with frame_tick wins, carrying the event into the next frame.
      r_hit_p1  <= (ball_pix & paddle_1_pix) | (r_hit_p1  & ~frame_tick);
      r_hit_p2  <= (ball_pix & paddle_2_pix) | (r_hit_p2  & ~frame_tick);
      r_hit_top <= (ball_pix & top_pix)      | (r_hit_top & ~frame_tick);
      r_hit_bot <= (ball_pix & bot_pix)      | (r_hit_bot & ~frame_tick);
    end
  end

  assign ball_x    = r_x;
  assign ball_y    = r_y;
  assign score_1   = r_s1;
  assign score_2   = r_s2;
  assign in_play   = r_in_play;
  assign game_over = r_game_over;

endmodule

// File: tb/tb_pong_ball_ctrl.sv
// tb_pong_ball_ctrl: directed bench for pong_ball_ctrl.
//   Walks reset, serve, paddle/wall bounces, flag carry-over, goals,
//   game over and asynchronous reset with hand-derived expected values.
module tb_pong_ball_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       ball_pix = 1'b0;
  logic       paddle_1_pix = 1'b0;
  logic       paddle_2_pix = 1'b0;
  logic       top_pix = 1'b0;
  logic       bot_pix = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [3:0] score_1;
  logic [3:0] score_2;
  logic       in_play;
  logic       game_over;

  int checks = 0;
  int fails  = 0;

  pong_ball_ctrl dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .ball_pix(ball_pix),
    .paddle_1_pix(paddle_1_pix), .paddle_2_pix(paddle_2_pix),
    .top_pix(top_pix), .bot_pix(bot_pix), .serve(serve),
    .ball_x(ball_x), .ball_y(ball_y), .score_1(score_1), .score_2(score_2),
    .in_play(in_play), .game_over(game_over)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_ball(input string tag, input int ex, input int ey);
    chk({tag, "_x"}, int'(ball_x), ex);
    chk({tag, "_y"}, int'(ball_y), ey);
  endtask

  // One frame: tick pulse then a few idle pixel clocks; returns on a negedge.
  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Mid-frame overlap pulse: 0=paddle1 1=paddle2 2=top 3=bottom.
  task automatic hit(input int which);
    @(negedge clk);
    ball_pix     = 1'b1;
    paddle_1_pix = (which == 0);
    paddle_2_pix = (which == 1);
    top_pix      = (which == 2);
    bot_pix      = (which == 3);
    @(negedge clk);
    ball_pix = 1'b0; paddle_1_pix = 1'b0; paddle_2_pix = 1'b0;
    top_pix = 1'b0; bot_pix = 1'b0;
  endtask

  task automatic press_serve();
    @(negedge clk) serve = 1'b1;
    @(negedge clk) serve = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_ball("rst_ball", 316, 236);
    chk("rst_s1", int'(score_1), 0);
    chk("rst_s2", int'(score_2), 0);
    chk("rst_play", int'(in_play), 0);
    chk("rst_over", int'(game_over), 0);

    // Serve with the button held high across the whole count
    @(negedge clk) serve = 1'b1;
    @(negedge clk);
    ticks(59);
    chk("serve_59_play", int'(in_play), 0);
    chk_ball("serve_59_ball", 316, 236);
    tick();
    chk("serve_60_play", int'(in_play), 1);
    chk_ball("serve_60_ball", 316, 236);
    serve = 1'b0;
    tick();
    chk_ball("first_move", 318, 238);

    // Right paddle reverses dx
    hit(1); tick();
    chk_ball("p2_bounce", 316, 240);
    // Bottom wall reverses dy
    hit(3); tick();
    chk_ball("bot_bounce", 314, 238);
    // Top overlap in the tick cycle is applied one frame later
    @(negedge clk);
    frame_tick = 1'b1; ball_pix = 1'b1; top_pix = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0; ball_pix = 1'b0; top_pix = 1'b0;
    @(negedge clk);
    chk_ball("top_same_tick", 312, 236);
    tick();
    chk_ball("top_carried", 310, 238);

    // Run to x=20 moving left, then left paddle bounce
    ticks(145);
    chk_ball("reach_20", 20, 528);
    hit(0); tick();
    chk_ball("p1_bounce", 22, 530);
    hit(0); tick();
    chk_ball("p1_no_double", 24, 532);

    // Head left to the edge
    hit(1); tick();
    chk_ball("p2_again", 22, 534);
    ticks(11);
    chk_ball("at_left_edge", 0, 556);
    // Paddle hit on a would-be goal tick: bounce, no score
    hit(0); tick();
    chk_ball("save_at_edge", 2, 558);
    chk("save_s2", int'(score_2), 0);
    chk("save_play", int'(in_play), 1);
    hit(1); tick();
    chk_ball("x2_step", 0, 560);
    tick();
    chk("goal_s2", int'(score_2), 1);
    chk("goal_s1", int'(score_1), 0);
    chk_ball("goal_ball", 316, 236);
    chk("goal_play", int'(in_play), 0);

    // Automatic relaunch toward the left player
    ticks(59);
    chk("relaunch_59", int'(in_play), 0);
    tick();
    chk("relaunch_60", int'(in_play), 1);
    tick();
    chk_ball("relaunch_move", 314, 238);
    hit(0); tick();
    chk("turn_right_x", int'(ball_x), 316);

    // Seven right goals end the game
    for (int i = 1; i <= 7; i++) begin
      if (i > 1) begin
        ticks(60);
        chk("rserve_play", int'(in_play), 1);
      end
      ticks(157);
      chk("near_right_x", int'(ball_x), 630);
      chk("near_right_s1", int'(score_1), i - 1);
      tick();
      chk("rgoal_s1", int'(score_1), i);
      chk_ball("rgoal_ball", 316, 236);
    end
    chk("over_flag", int'(game_over), 1);
    chk("over_play", int'(in_play), 0);
    chk("over_s2", int'(score_2), 1);
    ticks(3);
    chk_ball("over_frozen", 316, 236);
    chk("over_s1_held", int'(score_1), 7);

    // Serve from OVER clears scores and returns to IDLE
    press_serve();
    chk("clr_s1", int'(score_1), 0);
    chk("clr_s2", int'(score_2), 0);
    chk("clr_over", int'(game_over), 0);
    chk("clr_play", int'(in_play), 0);
    ticks(61);
    chk("idle_waits", int'(in_play), 0);

    // New game starts with both directions positive
    press_serve();
    ticks(60);
    chk("new_play", int'(in_play), 1);
    tick();
    chk_ball("new_move", 318, 238);

    // Asynchronous reset mid-play takes effect without a clock edge
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk_ball("arst_ball", 316, 236);
    chk("arst_play", int'(in_play), 0);
    chk("arst_s1", int'(score_1), 0);
    @(negedge clk) rst = 1'b0;

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/pong_ball_ctrl.md
Name: pong_ball_ctrl

Overview:
Frame-rate game controller that sequences the Pong ball datapath. It accumulates per-pixel overlap events from the video pipeline over each frame into sticky hit flags. At each frame boundary it uses those flags to reflect the ball velocity, advance the ball position, detect goals, keep score and run the serve / game-over state machine. It sits between the pixel-level overlap logic and the ball/score renderers.

Parameters:
H_RES, 640, active horizontal pixels
V_RES, 480, active vertical lines
BALL_SIZE, 8, ball edge length in pixels
SPEED, 2, pixels moved per frame on each axis
SERVE_FRAMES, 60, frame ticks between serve request and ball launch
WIN_SCORE, 7, score that ends the game
X_W, 10, width of ball_x
Y_W, 10, width of ball_y

Ports:
clk  in  1  pixel clock
rst  in  1  reset; asynchronous, active-high
frame_tick  in  1  one-clk pulse at start of vertical blanking, synchronous to clk
ball_pix  in  1  current pixel is inside the ball
paddle_1_pix  in  1  current pixel is inside the left paddle
paddle_2_pix  in  1  current pixel is inside the right paddle
top_pix  in  1  current pixel is inside the top wall
bot_pix  in  1  current pixel is inside the bottom wall
serve  in  1  level button, synchronised externally
ball_x  out  X_W  ball left edge
ball_y  out  Y_W  ball top edge
score_1  out  4  left player score
score_2  out  4  right player score
in_play  out  1  high only in PLAY
game_over  out  1  high only in OVER

Behaviour:
- Reset:
  - state IDLE; ball_x = (H_RES-BALL_SIZE)/2 = 316; ball_y = (V_RES-BALL_SIZE)/2 = 236.
  - dx = +SPEED, dy = +SPEED; scores 0; all hit flags 0; serve counter 0.
  - in_play = 0, game_over = 0.
- Hit flags (hit_p1, hit_p2, hit_top, hit_bot):
  - Each flag sets on any clk where ball_pix & its source pixel is 1.
  - All flags clear on frame_tick.
  - If a set and frame_tick occur in the same cycle, the set wins; the event is counted in the next frame.
  - Flags accumulate in every state but are consumed only in PLAY.
- serve edge:
  - serve_rise = serve & ~serve_q, with serve_q registered.
  - A held button produces exactly one event.
- States:
  - IDLE: ball centred. On serve_rise go to SERVE_WAIT and clear the counter.
  - SERVE_WAIT: ball centred. Counter increments on each frame_tick. When the counter reaches SERVE_FRAMES-1 on a frame_tick, go to PLAY. Launch occurs on the SERVE_FRAMES-th tick; position first moves on the following tick.
  - PLAY, on frame_tick, evaluated in this order on pre-update values:
    1. If hit_p1 and dx<0, set dx=+SPEED. If hit_p2 and dx>0, set dx=-SPEED. A hit while already moving away is ignored, so there is no double bounce.
    2. If hit_top and dy<0, set dy=+SPEED. If hit_bot and dy>0, set dy=-SPEED.
    3. Left goal: new dx<0 and ball_x < SPEED. score_2 increments and the next serve uses dx=-SPEED (toward the left player).
    4. Right goal: new dx>0 and ball_x+BALL_SIZE+SPEED > H_RES-1. score_1 increments and the next serve uses dx=+SPEED.
    5. On a goal: recentre the ball with no position step. Go to OVER if the new score equals WIN_SCORE, else SERVE_WAIT (counter cleared, automatic relaunch with no button needed).
    6. With no goal: ball_x += dx, ball_y += dy, in two's-complement at X_W/Y_W width.
    7. Between frame_ticks, position and state hold.
  - OVER: ball centred; scores frozen. On serve_rise, clear both scores, set dx=dy=+SPEED and go to IDLE.
- Outputs are registered. ball_x/ball_y change only on a frame_tick cycle, so they are stable for the whole visible frame.
- A paddle hit and a goal on the same tick: the bounce is applied first, so the goal test fails and there is no score.
- Scores never exceed WIN_SCORE.
- rst asserted mid-frame or mid-serve returns immediately to the reset values above.

Test Plan:
- Reset, then check outputs: ball (316,236); scores 0/0; in_play=0; game_over=0. Assert rst mid-PLAY: values return within the same cycle.
- Serve: serve_rise then 60 frame_ticks → in_play=1 after the 60th tick. Next tick → ball (318,238). Holding serve high across ticks does not restart the count.
- Paddle bounce: ball at x=20 with dx=-2; pulse ball_pix & paddle_1_pix mid-frame → after the tick dx=+2 and x=22. A second hit_p1 next frame leaves dx=+2.
- Wall and simultaneity: hit_bot with dy=+2 → dy=-2, y decreases by 2. hit_top and ball_pix & top_pix asserted in the same cycle as frame_tick → flag survives into the next frame.
- Goal: ball_x=1, dx=-2, no hit → score_2=1; ball (316,236); state SERVE_WAIT; after 60 ticks ball moves left.
- Game over: drive score_1 to 7 → game_over=1, ball frozen centred. serve_rise → scores 0/0, IDLE.
